dma_if_pcie_us_cpl: RTL and testbench

//  Ultrascale PCIe completer: target side of the requester DMA interface. Accepts host MemRd/MemWr TLPs on CQ,

---
 rtl/dma_if_pcie_us_cpl.sv | 277 +++++++++++++++++++++++++++
 tb/tb_dma_if_pcie_us_cpl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_if_pcie_us_cpl.sv
// Ultrascale PCIe completer: decodes single-DW host MemRd/MemWr TLPs arriving on
// the CQ stream, performs the access on a simple register port and returns a
// one-beat completion on the CC stream. Anything else is dropped, or answered
// with a UR/CA completion, and flagged on status_error_uncor.
module dma_if_pcie_us_cpl #(
   parameter int AXIS_PCIE_DATA_WIDTH    = 256,
   parameter int AXIS_PCIE_KEEP_WIDTH    = AXIS_PCIE_DATA_WIDTH / 32,
   parameter int AXIS_PCIE_CQ_USER_WIDTH = (AXIS_PCIE_DATA_WIDTH < 512) ? 88 : 183,
   parameter int AXIS_PCIE_CC_USER_WIDTH = (AXIS_PCIE_DATA_WIDTH < 512) ? 33 : 81,
   parameter int REG_ADDR_WIDTH          = 16,
   parameter int REG_TIMEOUT             = 1024
) (
   input  logic                               clk,
   input  logic                               rst_n,

   input  logic [AXIS_PCIE_DATA_WIDTH-1:0]    s_axis_cq_tdata,
   input  logic [AXIS_PCIE_KEEP_WIDTH-1:0]    s_axis_cq_tkeep,
   input  logic                               s_axis_cq_tvalid,
   output logic                               s_axis_cq_tready,
   input  logic                               s_axis_cq_tlast,
   input  logic [AXIS_PCIE_CQ_USER_WIDTH-1:0] s_axis_cq_tuser,

   output logic [AXIS_PCIE_DATA_WIDTH-1:0]    m_axis_cc_tdata,
   output logic [AXIS_PCIE_KEEP_WIDTH-1:0]    m_axis_cc_tkeep,
   output logic                               m_axis_cc_tvalid,
   input  logic                               m_axis_cc_tready,
   output logic                               m_axis_cc_tlast,
   output logic [AXIS_PCIE_CC_USER_WIDTH-1:0] m_axis_cc_tuser,

   output logic [REG_ADDR_WIDTH-1:0]          reg_wr_addr,
   output logic [31:0]                        reg_wr_data,
   output logic [3:0]                         reg_wr_strb,
   output logic                               reg_wr_en,
   input  logic                               reg_wr_ack,
   output logic [REG_ADDR_WIDTH-1:0]          reg_rd_addr,
   output logic                               reg_rd_en,
   input  logic [31:0]                        reg_rd_data,
   input  logic                               reg_rd_ack,

   input  logic [15:0]                        completer_id,
   input  logic                               enable,
   output logic                               status_error_uncor
);

   localparam int         CNT_W       = $clog2(REG_TIMEOUT + 1);
   localparam logic [3:0] TYPE_MEM_RD = 4'b0000;
   localparam logic [3:0] TYPE_MEM_WR = 4'b0001;
   localparam logic [2:0] CPL_SC      = 3'b000;
   localparam logic [2:0] CPL_UR      = 3'b001;
   localparam logic [2:0] CPL_CA      = 3'b100;

   typedef enum logic [2:0] {S_IDLE, S_REG_WR, S_REG_RD, S_CPL, S_DROP} state_t;

   state_t                    state_q, state_d, post_q, post_d;
   logic                      run_q, run_d;
   logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [4:0]                la_q, la_d;
   logic [3:0]                be_q, be_d;
   logic [15:0]               req_id_q, req_id_d;
   logic [7:0]                tag_q, tag_d;
   logic [2:0]                tc_q, tc_d, attr_q, attr_d, status_q, status_d;
   logic                      has_data_q, has_data_d;
   logic [31:0]               wr_data_q, wr_data_d, rd_data_q, rd_data_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic                      err_q, err_d;

   logic [10:0] cq_dw_cnt;
   logic [3:0]  cq_type;
   logic        cq_fire;
   logic        cnt_expired;
   state_t      cq_target;
   logic [2:0]  cq_status;
   logic        cq_err;
   logic        cpl_active;
   logic        unused_inputs;

   // Index of the lowest enabled byte lane (0 when no lane is enabled).
   function automatic logic [1:0] be_lo(input logic [3:0] be);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 3; i >= 0; i--) if (be[i]) r = 2'(i);
      return r;
   endfunction

   // Byte span covered by the enables, lowest to highest set lane inclusive.
   function automatic logic [12:0] be_span(input logic [3:0] be);
      logic [1:0] hi;
      hi = 2'd0;
      for (int i = 0; i < 4; i++) if (be[i]) hi = 2'(i);
      if (be == 4'd0) return 13'd1;
      return 13'(hi) - 13'(be_lo(be)) + 13'd1;
   endfunction

   assign cq_dw_cnt   = s_axis_cq_tdata[74:64];
   assign cq_type     = s_axis_cq_tdata[78:75];
   assign cq_fire     = s_axis_cq_tvalid && s_axis_cq_tready;
   assign cnt_expired = (cnt_q == CNT_W'(REG_TIMEOUT - 1));
   assign cpl_active  = (state_q == S_CPL);

   // Descriptor, tkeep and tuser bits beyond the decoded fields carry nothing we need.
   assign unused_inputs = ^{s_axis_cq_tdata, s_axis_cq_tkeep, s_axis_cq_tuser};

   // Classify the request on the first CQ beat: where it goes and how it is answered.
   always_comb begin
      cq_target = S_IDLE;
      cq_status = CPL_SC;
      cq_err    = 1'b0;
      if (cq_type == TYPE_MEM_WR && cq_dw_cnt == 11'd1) begin
         cq_target = S_REG_WR;
      end else if (cq_type == TYPE_MEM_RD && cq_dw_cnt == 11'd1) begin
         cq_target = S_REG_RD;
      end else if (cq_type == TYPE_MEM_RD) begin
         cq_target = S_CPL;
         cq_status = CPL_CA;
         cq_err    = 1'b1;
      end else if (cq_type >= 4'b0010 && cq_type <= 4'b0110) begin
         cq_target = S_CPL;
         cq_status = CPL_UR;
         cq_err    = 1'b1;
      end else begin
         cq_err    = 1'b1;
      end
   end

   // Next-state and datapath update for the request FSM.
   always_comb begin
      state_d    = state_q;
      post_d     = post_q;
      run_d      = 1'b1;
      addr_d     = addr_q;
      la_d       = la_q;
      be_d       = be_q;
      req_id_d   = req_id_q;
      tag_d      = tag_q;
      tc_d       = tc_q;
      attr_d     = attr_q;
      status_d   = status_q;
      has_data_d = has_data_q;
      wr_data_d  = wr_data_q;
      rd_data_d  = rd_data_q;
      cnt_d      = cnt_q;
      err_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cq_fire) begin
               addr_d     = {s_axis_cq_tdata[REG_ADDR_WIDTH-1:2], 2'b00};
               la_d       = s_axis_cq_tdata[6:2];
               be_d       = s_axis_cq_tuser[3:0];
               req_id_d   = s_axis_cq_tdata[95:80];
               tag_d      = s_axis_cq_tdata[103:96];
               tc_d       = s_axis_cq_tdata[123:121];
               attr_d     = s_axis_cq_tdata[126:124];
               wr_data_d  = s_axis_cq_tdata[159:128];
               rd_data_d  = 32'd0;
               has_data_d = 1'b0;
               status_d   = cq_status;
               cnt_d      = '0;
               err_d      = cq_err;
               // Extra payload beats must be swallowed before acting on the request.
               if (s_axis_cq_tlast) begin
                  state_d = cq_target;
               end else begin
                  state_d = S_DROP;
                  post_d  = cq_target;
               end
            end
         end
         S_DROP: begin
            if (s_axis_cq_tvalid && s_axis_cq_tlast) state_d = post_q;
         end
         S_REG_WR: begin
            // Ack takes priority over a timeout expiring in the same cycle.
            if (reg_wr_ack) begin
               state_d = S_IDLE;
            end else if (cnt_expired) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_REG_RD: begin
            if (reg_rd_ack) begin
               rd_data_d  = reg_rd_data;
               has_data_d = 1'b1;
               status_d   = CPL_SC;
               state_d    = S_CPL;
            end else if (cnt_expired) begin
               has_data_d = 1'b0;
               status_d   = CPL_CA;
               state_d    = S_CPL;
               err_d      = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_CPL: begin
            if (m_axis_cc_tready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and request registers, cleared immediately by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         post_q     <= S_IDLE;
         run_q      <= 1'b0;
         addr_q     <= '0;
         la_q       <= '0;
         be_q       <= '0;
         req_id_q   <= '0;
         tag_q      <= '0;
         tc_q       <= '0;
         attr_q     <= '0;
         status_q   <= '0;
         has_data_q <= 1'b0;
         wr_data_q  <= '0;
         rd_data_q  <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         post_q     <= post_d;
         run_q      <= run_d;
         addr_q     <= addr_d;
         la_q       <= la_d;
         be_q       <= be_d;
         req_id_q   <= req_id_d;
         tag_q      <= tag_d;
         tc_q       <= tc_d;
         attr_q     <= attr_d;
         status_q   <= status_d;
         has_data_q <= has_data_d;
         wr_data_q  <= wr_data_d;
         rd_data_q  <= rd_data_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
      end
   end

   // run_q keeps CQ tready low while in reset and for the first cycle after it.
   assign s_axis_cq_tready   = ((state_q == S_IDLE) && enable && run_q) || (state_q == S_DROP);
   assign reg_wr_en          = (state_q == S_REG_WR);
   assign reg_wr_addr        = addr_q;
   assign reg_wr_data        = wr_data_q;
   assign reg_wr_strb        = be_q;
   assign reg_rd_en          = (state_q == S_REG_RD);
   assign reg_rd_addr        = addr_q;
   assign status_error_uncor = err_q;

   assign m_axis_cc_tvalid = cpl_active;
   assign m_axis_cc_tlast  = cpl_active;
   assign m_axis_cc_tuser  = '0;
   assign m_axis_cc_tkeep  = cpl_active ? AXIS_PCIE_KEEP_WIDTH'(has_data_q ? 4'hF : 4'h7)
                                        : '0;

   // Completion descriptor plus optional data DW; zero whenever no completion is pending.
   always_comb begin
      m_axis_cc_tdata = '0;
      if (cpl_active) begin
         m_axis_cc_tdata[6:0]   = {la_q, be_lo(be_q)};
         m_axis_cc_tdata[28:16] = has_data_q ? be_span(be_q) : 13'd4;
         m_axis_cc_tdata[42:32] = has_data_q ? 11'd1 : 11'd0;
         m_axis_cc_tdata[45:43] = status_q;
         m_axis_cc_tdata[63:48] = req_id_q;
         m_axis_cc_tdata[71:64] = tag_q;
         m_axis_cc_tdata[87:72] = completer_id;
         m_axis_cc_tdata[88]    = 1'b1;
         m_axis_cc_tdata[91:89] = tc_q;
         m_axis_cc_tdata[94:92] = attr_q;
         m_axis_cc_tdata[127:96] = has_data_q ? rd_data_q : 32'd0;
      end
   end

endmodule

// File: tb/tb_dma_if_pcie_us_cpl.sv
// Directed bench for dma_if_pcie_us_cpl: host TLPs in, register port and CC checked.
module tb_dma_if_pcie_us_cpl;

   localparam logic [15:0] CID = 16'hABCD;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [255:0] cq_tdata;
   logic [7:0]   cq_tkeep;
   logic         cq_tvalid, cq_tready, cq_tlast;
   logic [87:0]  cq_tuser;
   logic [255:0] cc_tdata;
   logic [7:0]   cc_tkeep;
   logic         cc_tvalid, cc_tready, cc_tlast;
   logic [32:0]  cc_tuser;
   logic [15:0]  wr_addr, rd_addr;
   logic [31:0]  wr_data, rd_data;
   logic [3:0]   wr_strb;
   logic         wr_en, wr_ack, rd_en, rd_ack;
   logic         enable, err;

   int vectors = 0;
   int miscompares = 0;
   int cc_beats = 0;
   int err_pulses = 0;

   always #5 clk = ~clk;

   dma_if_pcie_us_cpl dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_cq_tdata(cq_tdata), .s_axis_cq_tkeep(cq_tkeep), .s_axis_cq_tvalid(cq_tvalid),
      .s_axis_cq_tready(cq_tready), .s_axis_cq_tlast(cq_tlast), .s_axis_cq_tuser(cq_tuser),
      .m_axis_cc_tdata(cc_tdata), .m_axis_cc_tkeep(cc_tkeep), .m_axis_cc_tvalid(cc_tvalid),
      .m_axis_cc_tready(cc_tready), .m_axis_cc_tlast(cc_tlast), .m_axis_cc_tuser(cc_tuser),
      .reg_wr_addr(wr_addr), .reg_wr_data(wr_data), .reg_wr_strb(wr_strb), .reg_wr_en(wr_en),
      .reg_wr_ack(wr_ack), .reg_rd_addr(rd_addr), .reg_rd_en(rd_en), .reg_rd_data(rd_data),
      .reg_rd_ack(rd_ack), .completer_id(CID), .enable(enable), .status_error_uncor(err)
   );

   // Count completed CC beats and error-pulse cycles.
   always @(posedge clk) begin
      if (cc_tvalid && cc_tready) cc_beats <= cc_beats + 1;
      if (err) err_pulses <= err_pulses + 1;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
      $display("vec %0d %s obs=%0h exp=%0h", vectors, tag, obs, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Present one CQ beat and hold it until accepted; returns at the negedge after acceptance.
   task automatic send_cq(input logic [63:0] addr, input logic [10:0] dwc, input logic [3:0] typ,
                          input logic [15:0] rid, input logic [7:0] tg, input logic [2:0] tc,
                          input logic [2:0] at, input logic [3:0] be, input logic [31:0] d,
                          input logic last);
      logic [255:0] b;
      int n;
      logic ok;
      b = '0;
      b[63:0]    = {addr[63:2], 2'b00};
      b[74:64]   = dwc;
      b[78:75]   = typ;
      b[95:80]   = rid;
      b[103:96]  = tg;
      b[123:121] = tc;
      b[126:124] = at;
      b[159:128] = d;
      cq_tdata  = b;
      cq_tuser  = '0;
      cq_tuser[3:0] = be;
      cq_tkeep  = 8'hFF;
      cq_tlast  = last;
      cq_tvalid = 1'b1;
      n = 0;
      ok = 1'b0;
      while (!ok && n < 50) begin
         ok = cq_tready;
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      cq_tvalid = 1'b0;
      cq_tlast  = 1'b0;
      chk("cq_accept", 256'(ok), 256'd1);
   endtask

   function automatic logic [255:0] cc_desc(input logic [6:0] la, input logic [12:0] bc,
                                            input logic [10:0] dwc, input logic [2:0] st,
                                            input logic [15:0] rid, input logic [7:0] tg,
                                            input logic [2:0] tc, input logic [2:0] at,
                                            input logic [31:0] d);
      logic [255:0] v;
      v = '0;
      v[6:0] = la;     v[28:16] = bc;   v[42:32] = dwc;  v[45:43] = st;
      v[63:48] = rid;  v[71:64] = tg;   v[87:72] = CID;  v[88] = 1'b1;
      v[91:89] = tc;   v[94:92] = at;   v[127:96] = d;
      return v;
   endfunction

   // Release CC backpressure for one beat and confirm the completion left.
   task automatic drain_cc(input string tag);
      cc_tready = 1'b1;
      cyc(1);
      cc_tready = 1'b0;
      chk(tag, 256'(cc_tvalid), 256'd0);
   endtask

   initial begin
      int n;
      rst_n = 1'b0; enable = 1'b1; cq_tvalid = 1'b0; cq_tlast = 1'b0;
      cq_tdata = '0; cq_tkeep = '0; cq_tuser = '0; cc_tready = 1'b0;
      wr_ack = 1'b0; rd_ack = 1'b0; rd_data = '0;

      // Reset state
      cyc(2);
      chk("rst_cq_tready", 256'(cq_tready), 256'd0);
      chk("rst_cc_tvalid", 256'(cc_tvalid), 256'd0);
      chk("rst_rd_en", 256'(rd_en), 256'd0);
      chk("rst_wr_en", 256'(wr_en), 256'd0);
      chk("rst_err", 256'(err), 256'd0);
      rst_n = 1'b1;
      cyc(2);
      chk("idle_cq_tready", 256'(cq_tready), 256'd1);

      // Posted single-DW write
      send_cq(64'h1004, 11'd1, 4'b0001, 16'h0100, 8'h01, 3'd0, 3'd0, 4'hF, 32'hDEADBEEF, 1'b1);
      chk("wr_en", 256'(wr_en), 256'd1);
      chk("wr_addr", 256'(wr_addr), 256'h1004);
      chk("wr_strb", 256'(wr_strb), 256'hF);
      chk("wr_data", 256'(wr_data), 256'hDEADBEEF);
      chk("wr_cq_tready", 256'(cq_tready), 256'd0);
      cyc(1);
      wr_ack = 1'b1;
      cyc(1);
      wr_ack = 1'b0;
      chk("wr_en_after_ack", 256'(wr_en), 256'd0);
      cyc(1);
      chk("wr_no_cc", 256'(cc_beats), 256'd0);

      // Read, ack three cycles after acceptance
      send_cq(64'h0010, 11'd1, 4'b0000, 16'h0100, 8'h2A, 3'd0, 3'd0, 4'hF, 32'h0, 1'b1);
      chk("rd_en", 256'(rd_en), 256'd1);
      chk("rd_addr", 256'(rd_addr), 256'h0010);
      cyc(2);
      rd_ack = 1'b1; rd_data = 32'h12345678;
      cyc(1);
      rd_ack = 1'b0;
      chk("rd_en_after_ack", 256'(rd_en), 256'd0);
      chk("rd1_tvalid", 256'(cc_tvalid), 256'd1);
      chk("rd1_desc", cc_tdata,
          cc_desc(7'h10, 13'd4, 11'd1, 3'b000, 16'h0100, 8'h2A, 3'd0, 3'd0, 32'h12345678));
      chk("rd1_tkeep", 256'(cc_tkeep), 256'h0F);
      chk("rd1_tlast", 256'(cc_tlast), 256'd1);
      chk("rd1_tuser", 256'(cc_tuser), 256'd0);
      drain_cc("rd1_drained");

      // Partial-byte read under CC backpressure
      send_cq(64'h0008, 11'd1, 4'b0000, 16'h0203, 8'h11, 3'd2, 3'd1, 4'h6, 32'h0, 1'b1);
      rd_ack = 1'b1; rd_data = 32'hCAFEF00D;
      cyc(1);
      rd_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("rd2_desc_held", cc_tdata,
             cc_desc(7'h09, 13'd2, 11'd1, 3'b000, 16'h0203, 8'h11, 3'd2, 3'd1, 32'hCAFEF00D));
         chk("rd2_cq_tready", 256'(cq_tready), 256'd0);
         cyc(1);
      end
      drain_cc("rd2_drained");

      // Read with no ack: timeout after REG_TIMEOUT cycles, CA without data
      send_cq(64'h0020, 11'd1, 4'b0000, 16'h0100, 8'h33, 3'd0, 3'd0, 4'hF, 32'h0, 1'b1);
      n = 0;
      while (rd_en && n < 2000) begin
         n++;
         cyc(1);
      end
      chk("tmo_cycles", 256'(n), 256'd1024);
      chk("tmo_err_pulse", 256'(err), 256'd1);
      chk("tmo_desc", cc_tdata,
          cc_desc(7'h20, 13'd4, 11'd0, 3'b100, 16'h0100, 8'h33, 3'd0, 3'd0, 32'h0));
      chk("tmo_tkeep", 256'(cc_tkeep), 256'h07);
      drain_cc("tmo_drained");
      chk("tmo_err_count", 256'(err_pulses), 256'd1);

      // Multi-DW read spanning two beats: both consumed, CA
      send_cq(64'h0040, 11'd4, 4'b0000, 16'h0100, 8'h3C, 3'd0, 3'd0, 4'hF, 32'h0, 1'b0);
      chk("mdw_drop_tready", 256'(cq_tready), 256'd1);
      send_cq(64'h0, 11'd0, 4'b0000, 16'h0, 8'h0, 3'd0, 3'd0, 4'h0, 32'h0, 1'b1);
      chk("mdw_desc", cc_tdata,
          cc_desc(7'h40, 13'd4, 11'd0, 3'b100, 16'h0100, 8'h3C, 3'd0, 3'd0, 32'h0));
      chk("mdw_cq_tready", 256'(cq_tready), 256'd0);
      drain_cc("mdw_drained");

      // IO read: UR without data
      send_cq(64'h0004, 11'd1, 4'b0010, 16'h0500, 8'h44, 3'd0, 3'd0, 4'h1, 32'h0, 1'b1);
      chk("io_desc", cc_tdata,
          cc_desc(7'h04, 13'd4, 11'd0, 3'b001, 16'h0500, 8'h44, 3'd0, 3'd0, 32'h0));
      chk("io_tkeep", 256'(cc_tkeep), 256'h07);
      drain_cc("io_drained");

      // Multi-DW write is discarded with an error pulse and no completion
      send_cq(64'h0100, 11'd2, 4'b0001, 16'h0100, 8'h00, 3'd0, 3'd0, 4'hF, 32'h1, 1'b1);
      chk("disc_err", 256'(err), 256'd1);
      chk("disc_wr_en", 256'(wr_en), 256'd0);
      chk("disc_cq_tready", 256'(cq_tready), 256'd1);
      cyc(1);
      chk("disc_err_one_cycle", 256'(err), 256'd0);
      chk("disc_err_count", 256'(err_pulses), 256'd4);
      chk("disc_cc_beats", 256'(cc_beats), 256'd5);

      // enable dropped mid-request: request completes, nothing new accepted
      send_cq(64'h0014, 11'd1, 4'b0000, 16'h0300, 8'h55, 3'd0, 3'd0, 4'hC, 32'h0, 1'b1);
      enable = 1'b0;
      rd_ack = 1'b1; rd_data = 32'hA5A5A5A5;
      cyc(1);
      rd_ack = 1'b0;
      chk("en_desc", cc_tdata,
          cc_desc(7'h16, 13'd2, 11'd1, 3'b000, 16'h0300, 8'h55, 3'd0, 3'd0, 32'hA5A5A5A5));
      drain_cc("en_drained");
      cq_tvalid = 1'b1; cq_tlast = 1'b1; cq_tdata = '0; cq_tdata[74:64] = 11'd1;
      cyc(3);
      chk("en_low_tready", 256'(cq_tready), 256'd0);
      chk("en_low_no_rd", 256'(rd_en), 256'd0);
      cq_tvalid = 1'b0; cq_tlast = 1'b0;
      enable = 1'b1;
      cyc(1);

      // Reset during a register read, then a normal read
      send_cq(64'h0028, 11'd1, 4'b0000, 16'h0100, 8'h77, 3'd0, 3'd0, 4'hF, 32'h0, 1'b1);
      chk("prerst_rd_en", 256'(rd_en), 256'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_rd_en", 256'(rd_en), 256'd0);
      chk("midrst_cc_tvalid", 256'(cc_tvalid), 256'd0);
      chk("midrst_cq_tready", 256'(cq_tready), 256'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(2);
      send_cq(64'h0030, 11'd1, 4'b0000, 16'h0100, 8'h66, 3'd0, 3'd0, 4'h8, 32'h0, 1'b1);
      rd_ack = 1'b1; rd_data = 32'h0BADCAFE;
      cyc(1);
      rd_ack = 1'b0;
      chk("postrst_desc", cc_tdata,
          cc_desc(7'h33, 13'd1, 11'd1, 3'b000, 16'h0100, 8'h66, 3'd0, 3'd0, 32'h0BADCAFE));
      drain_cc("postrst_drained");
      chk("total_cc_beats", 256'(cc_beats), 256'd7);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
